uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO and a valid/ready input handshake. It replaces the single-byte, pulse-triggered transmitter with one that supports configurable data width, parity and stop bits, and queues up to FIFO_DEPTH words. Queued frames are sent back-to-back with no idle gap. It sits between on-chip producers (for example, a character generator in top-level logic) and the board uart_tx pin.

Parameters:
CLOCK_SPEED, 27000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate; bit period CLOCK_DELAY = CLOCK_SPEED/BAUD_RATE cycles (truncating); elaboration error if CLOCK_DELAY < 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
dataIn  input  DATA_BITS  word to transmit.
dataValid  input  1  producer offers dataIn this cycle.
dataReady  output  1  FIFO can accept a word; equals (fifoCount != FIFO_DEPTH).
uart_tx  output  1  serial line, idle high.
txBusy  output  1  high while a frame is on the line or FIFO non-empty.
fifoCount  output  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the word being shifted.

Behaviour:
- Reset (async assert, sync release):
  - uart_tx=1, txBusy=0, fifoCount=0, dataReady=1.
  - FIFO pointers cleared; state=IDLE; baud counter=0.
  - A frame in progress is aborted; the line returns high immediately.
- Push: on a rising edge with dataValid && dataReady, dataIn is written and fifoCount increments.
  - dataReady depends only on fifoCount. When full, a push is refused even if a pop happens in the same cycle.
- Pop: the head word moves to the shift register in two cases:
  - state==IDLE with FIFO non-empty;
  - the last cycle of the final stop bit with FIFO non-empty.
  - Simultaneous push and pop leaves fifoCount unchanged. The FIFO is not fall-through: a word written into an empty FIFO is popped on the next edge at the earliest.
- Serializer states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when a pop occurs.
  - START: uart_tx=0 for CLOCK_DELAY cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLOCK_DELAY cycles; a bit index counter selects the bit.
  - PARITY (skipped when PARITY=0): odd makes the total count of ones in data+parity odd; even makes it even.
  - STOP: uart_tx=1 for STOP_BITS*CLOCK_DELAY cycles.
- Timing:
  - uart_tx is registered. The start-bit falling edge appears on the edge after the pop, so the line falls 2 cycles after the accepting push edge into an empty idle block.
  - Baud counter runs 0..CLOCK_DELAY-1 and restarts at each pop.
  - Every bit lasts exactly CLOCK_DELAY cycles.
  - Back-to-back frames: falling edge to falling edge = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLOCK_DELAY cycles exactly.
- txBusy = (state != IDLE) || (fifoCount != 0). It drops on the edge where STOP completes into IDLE with an empty FIFO.
- Inputs are ignored while reset is high.

Test Plan:
All cases use CLOCK_SPEED=1000, BAUD_RATE=100 (CLOCK_DELAY=10), DATA_BITS=8, PARITY=0, STOP_BITS=1 unless stated.
1. Single push of 0x21 -> uart_tx falls 2 cycles later; line sampled at bit centres reads 0,1,0,0,0,0,1,0,0,1 (start, LSB-first data, stop); frame is 100 cycles; txBusy falls at frame end.
2. Push 0x41, 0x42, 0x43 on consecutive cycles -> fifoCount peaks at 2; three frames with exactly 100-cycle start spacing and no idle high between stop and next start.
3. FIFO_DEPTH=4, hold dataValid with 6 distinct words -> dataReady low when fifoCount=4; exactly the accepted words are sent, in order; no word is lost or duplicated.
4. PARITY=1, then PARITY=2, with DATA_BITS=7, STOP_BITS=2, word 0x55 -> parity bit 1 (odd) / 0 (even); stop high for 20 cycles; frame is 110 cycles.
5. Assert reset 35 cycles into a frame with 2 words queued -> uart_tx=1 without waiting for a clock edge; fifoCount=0, txBusy=0; after release, the line stays high until the next push.
6. Push on the same cycle as a pop with fifoCount=3 -> fifoCount stays 3; the pushed word is transmitted last.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO with a valid/ready push interface.
// Frames: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_SPEED = 27000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          dataIn,
    input  logic                          dataValid,
    output logic                          dataReady,
    output logic                          uart_tx,
    output logic                          txBusy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
    localparam int unsigned CLOCK_DELAY = CLOCK_SPEED / BAUD_RATE;
    localparam int unsigned CW = $clog2(CLOCK_DELAY);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    if (CLOCK_DELAY < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLOCK_SPEED/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
        $error("uart_tx_fifo: PARITY must be 0..2 and STOP_BITS 1..2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        baud_cnt, baud_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 tx_n;
    logic                 push, pop, baud_last, fifo_empty;
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    assign dataReady  = (fifoCount != (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifoCount == '0);
    assign push       = dataValid && dataReady;
    assign baud_last  = (baud_cnt == CW'(CLOCK_DELAY - 1));
    assign txBusy     = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= dataIn;
    end

    // uart_tx is the registered image of the current state, so the line lags the FSM by one cycle
    always_comb begin
        state_n = state;
        baud_n  = baud_last ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        par_n   = par_bit;
        tx_n    = 1'b1;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                tx_n = shreg[bit_idx];
                if (baud_last) begin
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                tx_n = par_bit;
                if (baud_last) state_n = S_STOP;
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_idx == BW'(STOP_BITS - 1)) begin
                        bit_n = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (pop) begin
            shreg_n = mem[rd_ptr];
            par_n   = (^mem[rd_ptr]) ^ (PARITY == 1);
            baud_n  = '0;
            bit_n   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            uart_tx   <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifoCount <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            par_bit  <= par_n;
            uart_tx  <= tx_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations sharing one clock and reset.
module tb_uart_tx_fifo;
    localparam int CD = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] din [4];
    logic       dv  [4];
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       tx0, tx1, tx2, tx3;
    logic       busy0, busy1, busy2, busy3;
    logic [4:0] cnt0, cnt2, cnt3;
    logic [2:0] cnt1;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clock(clock), .reset(reset), .dataIn(din[0][7:0]), .dataValid(dv[0]),
        .dataReady(rdy0), .uart_tx(tx0), .txBusy(busy0), .fifoCount(cnt0));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .dataIn(din[1][7:0]), .dataValid(dv[1]),
        .dataReady(rdy1), .uart_tx(tx1), .txBusy(busy1), .fifoCount(cnt1));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
        .clock(clock), .reset(reset), .dataIn(din[2][6:0]), .dataValid(dv[2]),
        .dataReady(rdy2), .uart_tx(tx2), .txBusy(busy2), .fifoCount(cnt2));
    uart_tx_fifo #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) dut3 (
        .clock(clock), .reset(reset), .dataIn(din[3][6:0]), .dataValid(dv[3]),
        .dataReady(rdy3), .uart_tx(tx3), .txBusy(busy3), .fifoCount(cnt3));

    function automatic logic get_tx(int c);
        case (c) 0: return tx0; 1: return tx1; 2: return tx2; default: return tx3; endcase
    endfunction
    function automatic logic get_busy(int c);
        case (c) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
    endfunction
    function automatic logic get_rdy(int c);
        case (c) 0: return rdy0; 1: return rdy1; 2: return rdy2; default: return rdy3; endcase
    endfunction
    function automatic logic [4:0] get_cnt(int c);
        case (c) 0: return cnt0; 1: return {2'b00, cnt1}; 2: return cnt2; default: return cnt3; endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_fall(input int c, input int limit, output int n);
        n = 0;
        while (get_tx(c) === 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Entered one step after the edge that drove the start bit; leaves at the stop-bit centre.
    task automatic rx_word(input int c, output logic [7:0] w, output logic ok);
        repeat (5) tick();
        ok = (get_tx(c) === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CD) tick();
            w[i] = get_tx(c);
        end
        repeat (CD) tick();
        ok = ok && (get_tx(c) === 1'b1);
    endtask

    typedef struct {
        int         cfg;
        logic [8:0] word;
        string      exp;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] w3 [6];
    logic [7:0] w6 [5];
    int         n, nb, hi;
    logic       saw_full;

    initial begin
        // line samples at bit centres, start bit first
        vecs[0] = '{0, 9'h021, "0100001001"};
        vecs[1] = '{0, 9'h0A5, "0101001011"};
        vecs[2] = '{0, 9'h000, "0000000001"};
        vecs[3] = '{0, 9'h0FF, "0111111111"};
        vecs[4] = '{1, 9'h03C, "0001111001"};
        vecs[5] = '{2, 9'h055, "01010101111"};
        vecs[6] = '{3, 9'h055, "01010101011"};
        w3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        w6 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            dv[c]  = 1'b0;
            din[c] = '0;
        end
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_tx%0d", c), get_tx(c), 1);
            check($sformatf("rst_busy%0d", c), get_busy(c), 0);
            check($sformatf("rst_cnt%0d", c), get_cnt(c), 0);
            check($sformatf("rst_rdy%0d", c), get_rdy(c), 1);
        end
        reset = 1'b0;
        repeat (2) tick();

        // single frames, including parity and two stop bits
        for (int i = 0; i < 7; i++) begin
            int c;
            c  = vecs[i].cfg;
            nb = vecs[i].exp.len();
            din[c] = vecs[i].word;
            dv[c]  = 1'b1;
            tick();
            dv[c]  = 1'b0;
            wait_fall(c, 50, n);
            check($sformatf("v%0d_fall_latency", i), n, 2);
            for (int k = 0; k < nb; k++) begin
                repeat ((k == 0) ? 5 : CD) tick();
                check($sformatf("v%0d_bit%0d", i, k), get_tx(c), (vecs[i].exp[k] == "1") ? 1 : 0);
            end
            repeat (3) tick();
            check($sformatf("v%0d_busy_end", i), get_busy(c), 1);
            tick();
            check($sformatf("v%0d_busy_drop", i), get_busy(c), 0);
            repeat (3) tick();
            check($sformatf("v%0d_idle_high", i), get_tx(c), 1);
        end

        // three back-to-back frames
        fork
            begin
                din[0] = 9'h041; dv[0] = 1'b1; tick();
                check("b2b_cnt_a", cnt0, 1);
                din[0] = 9'h042; tick();
                check("b2b_cnt_b", cnt0, 1);
                din[0] = 9'h043; tick();
                check("b2b_cnt_peak", cnt0, 2);
                dv[0] = 1'b0;
            end
            begin
                logic [7:0] w;
                logic ok;
                wait_fall(0, 50, n);
                check("b2b_first_fall", n, 3);
                for (int f = 0; f < 3; f++) begin
                    rx_word(0, w, ok);
                    check($sformatf("b2b_word%0d", f), w, 8'h41 + f);
                    check($sformatf("b2b_frame%0d", f), ok, 1);
                    if (f < 2) begin
                        wait_fall(0, 20, n);
                        check($sformatf("b2b_spacing%0d", f), n, 5);
                    end
                end
                repeat (3) tick();
                check("b2b_busy_end", busy0, 1);
                tick();
                check("b2b_busy_drop", busy0, 0);
            end
        join
        repeat (5) tick();

        // depth-4 FIFO held under continuous dataValid
        saw_full = 1'b0;
        fork
            begin
                int k, cyc;
                logic acc;
                k = 0;
                cyc = 0;
                while (k < 6 && cyc < 2000) begin
                    din[1] = {1'b0, w3[k]};
                    dv[1]  = 1'b1;
                    acc    = rdy1;
                    if (cnt1 == 3'd4 && !saw_full) begin
                        saw_full = 1'b1;
                        check("full_ready_low", rdy1, 0);
                    end
                    tick();
                    if (acc) k++;
                    cyc++;
                end
                dv[1] = 1'b0;
                check("full_all_accepted", k, 6);
                check("full_saw_full", saw_full, 1);
            end
            begin
                logic [7:0] w;
                logic ok;
                for (int f = 0; f < 6; f++) begin
                    wait_fall(1, 300, n);
                    rx_word(1, w, ok);
                    check($sformatf("full_word%0d", f), w, w3[f]);
                    check($sformatf("full_frame%0d", f), ok, 1);
                end
                wait_fall(1, 150, n);
                check("full_no_extra_frame", n, 150);
                check("full_busy_idle", busy1, 0);
            end
        join
        repeat (5) tick();

        // push coinciding with a pop at fifoCount=3
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    din[0] = {1'b0, w6[j]};
                    dv[0]  = 1'b1;
                    tick();
                end
                dv[0] = 1'b0;
                check("pp_cnt_before", cnt0, 3);
                repeat (97) tick();
                check("pp_cnt_at_stop", cnt0, 3);
                din[0] = {1'b0, w6[4]};
                dv[0]  = 1'b1;
                tick();
                dv[0]  = 1'b0;
                check("pp_cnt_same", cnt0, 3);
                tick();
                check("pp_cnt_hold", cnt0, 3);
            end
            begin
                logic [7:0] w;
                logic ok;
                for (int f = 0; f < 5; f++) begin
                    wait_fall(0, 120, n);
                    rx_word(0, w, ok);
                    check($sformatf("pp_word%0d", f), w, w6[f]);
                    check($sformatf("pp_frame%0d", f), ok, 1);
                end
            end
        join
        repeat (10) tick();

        // asynchronous reset in mid-frame with two words queued
        for (int j = 0; j < 3; j++) begin
            din[0] = 9'h031 + 9'(j);
            dv[0]  = 1'b1;
            tick();
        end
        dv[0] = 1'b0;
        repeat (35) tick();
        check("ar_cnt_before", cnt0, 2);
        check("ar_line_low_before", tx0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_tx_async", tx0, 1);
        check("ar_cnt_async", cnt0, 0);
        check("ar_busy_async", busy0, 0);
        check("ar_rdy_async", rdy0, 1);
        din[0] = 9'h077;
        dv[0]  = 1'b1;
        repeat (3) tick();
        check("ar_push_ignored", cnt0, 0);
        dv[0]  = 1'b0;
        reset  = 1'b0;
        hi = 0;
        for (int j = 0; j < 200; j++) begin
            tick();
            if (tx0 === 1'b1) hi++;
        end
        check("ar_line_stays_high", hi, 200);
        check("ar_busy_after", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
